vga_scanout: RTL and testbench

Display stage downstream of the game logic: continuously reads the 320x240, 2-bit-per-pixel playfield RAM through its read-only port and drives a 640x480@60 Hz VGA signal, doubling each playfield pixel horizontally and vertically. It runs on the 50 MHz system clock, advancing one VGA pixel every two clocks. It also emits a once-per-frame pulse that marks the start of vertical blanking.

---
 rtl/vga_scanout.sv | 109 ++++++++++
 tb/tb_vga_scanout.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA scanout: reads the 2bpp playfield RAM and drives a 640x480@60 VGA
// signal at half the system clock, pixel-doubled in both directions.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FB_WIDTH  = 320
) (
  input  logic        clock,
  input  logic        reset,
  output logic [18:0] fb_address,
  input  logic [1:0]  fb_read_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO   = H_VISIBLE + H_FRONT;
  localparam int HS_HI   = HS_LO + H_SYNC - 1;
  localparam int VS_LO   = V_VISIBLE + V_FRONT;
  localparam int VS_HI   = VS_LO + V_SYNC - 1;

  logic        r_phase;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic        r_hsync;
  logic        r_vsync;
  logic [11:0] r_rgb;
  logic        r_fs;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_visible;
  logic        w_hsync;
  logic        w_vsync;
  logic [18:0] w_addr;
  logic [11:0] w_colour;

  assign w_h_last  = (r_h == 10'(H_TOTAL - 1));
  assign w_v_last  = (r_v == 10'(V_TOTAL - 1));
  assign w_visible = (r_h < 10'(H_VISIBLE))
                  && (r_v < 10'(V_VISIBLE));

  assign w_addr = 19'(FB_WIDTH) * 19'(r_v >> 1)
                + 19'(r_h >> 1);
  assign fb_address = w_visible ? w_addr : '0;

  assign w_hsync = !((r_h >= 10'(HS_LO))
                  && (r_h <= 10'(HS_HI)));
  assign w_vsync = !((r_v >= 10'(VS_LO))
                  && (r_v <= 10'(VS_HI)));

  always_comb begin
    w_colour = 12'h000;
    case (fb_read_data)
      2'b01:   w_colour = 12'hF00;
      2'b10:   w_colour = 12'h0FF;
      2'b11:   w_colour = 12'hFFF;
      default: w_colour = 12'h000;
    endcase
  end

  // Outputs load on the phase-1 edge, one clock after RAM sampled the address.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_phase <= 1'b0;
      r_h     <= '0;
      r_v     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      r_fs    <= 1'b0;
      if (r_phase) begin
        r_hsync <= w_hsync;
        r_vsync <= w_vsync;
        r_rgb   <= w_visible ? w_colour : 12'h000;
        r_fs    <= w_h_last
                && (r_v == 10'(V_VISIBLE - 1));
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size and a shrunken-timing instance are
// compared every clock against an arithmetic model of the raster.
module tb_vga_scanout;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  logic        mode = 1'b0;
  logic [31:0] seed = 32'h0;

  logic [18:0] d_addr, s_addr;
  logic [1:0]  d_rd, s_rd;
  logic        d_hs, d_vs, d_fs, s_hs, s_vs, s_fs;
  logic [3:0]  d_r, d_g, d_b, s_r, s_g, s_b;

  vga_scanout d (
    .clock(clk), .reset(reset),
    .fb_address(d_addr), .fb_read_data(d_rd),
    .vga_hsync(d_hs), .vga_vsync(d_vs),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .frame_start(d_fs)
  );

  vga_scanout #(
    .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(16), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .FB_WIDTH(16)
  ) s (
    .clock(clk), .reset(reset),
    .fb_address(s_addr), .fb_read_data(s_rd),
    .vga_hsync(s_hs), .vga_vsync(s_vs),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .frame_start(s_fs)
  );

  function automatic logic [1:0] ramf(input logic [18:0] a);
    logic [31:0] t;
    if (mode) return (a == 19'd5) ? 2'b01 : 2'b00;
    t = ({13'd0, a} ^ seed) * 32'h9E3779B1;
    return t[31:30];
  endfunction

  always @(posedge clk) begin
    d_rd <= ramf(d_addr);
    s_rd <= ramf(s_addr);
  end

  function automatic logic [11:0] colour(input logic [1:0] c);
    case (c)
      2'b01:   return 12'hF00;
      2'b10:   return 12'h0FF;
      2'b11:   return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  int total = 0;
  int bad = 0;
  int n = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h",
             tag, n, got, exp);
    end
  endtask

  // Counters derive from n, the number of clocks since reset release:
  // pixel n/2 is being addressed, pixel n/2-1 is on the pins.
  task automatic model(
    input int hv, hf, hsw, hb, vv, vf, vsw, vb, fbw,
    output logic [18:0] ea, output logic [11:0] ergb,
    output logic ehs, evs, efs);
    int ht, vt, p, h, v, q, hq, vq, qa;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p = (n / 2) % (ht * vt);
    h = p % ht;
    v = p / ht;
    ea = (h < hv && v < vv) ? 19'(fbw * (v / 2) + h / 2) : 19'd0;
    ergb = 12'h000; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
    if (n >= 2) begin
      q = (n / 2 - 1) % (ht * vt);
      hq = q % ht;
      vq = q / ht;
      ehs = !(hq >= hv + hf && hq < hv + hf + hsw);
      evs = !(vq >= vv + vf && vq < vv + vf + vsw);
      qa = fbw * (vq / 2) + hq / 2;
      if (hq < hv && vq < vv) ergb = colour(ramf(19'(qa)));
      efs = (n % 2 == 0) && hq == ht - 1 && vq == vv - 1;
    end
  endtask

  int d_hs_first, d_hs_cnt, d_red_cnt, d_red_first;
  int s_vs_first, s_vs_cnt, s_addr_max;
  logic [18:0] d_addr_l2, d_addr_639;
  int s_fs_q[$];

  task automatic clear_stats();
    d_hs_first = -1; d_hs_cnt = 0;
    d_red_cnt = 0; d_red_first = -1;
    s_vs_first = -1; s_vs_cnt = 0; s_addr_max = 0;
    d_addr_l2 = '1; d_addr_639 = '1;
    s_fs_q.delete();
  endtask

  task automatic check_all();
    logic [18:0] ea;
    logic [11:0] ergb;
    logic ehs, evs, efs;
    model(640, 16, 96, 48, 480, 10, 2, 33, 320,
          ea, ergb, ehs, evs, efs);
    chk("d_addr", 32'(d_addr), 32'(ea));
    chk("d_rgb", 32'({d_r, d_g, d_b}), 32'(ergb));
    chk("d_sync", 32'({d_hs, d_vs}), 32'({ehs, evs}));
    chk("d_fs", 32'(d_fs), 32'(efs));
    model(32, 4, 6, 4, 16, 2, 2, 3, 16,
          ea, ergb, ehs, evs, efs);
    chk("s_addr", 32'(s_addr), 32'(ea));
    chk("s_rgb", 32'({s_r, s_g, s_b}), 32'(ergb));
    chk("s_sync", 32'({s_hs, s_vs}), 32'({ehs, evs}));
    chk("s_fs", 32'(s_fs), 32'(efs));
    if (n >= 2 && n < 1602) begin
      if (d_hs === 1'b0) begin
        if (d_hs_first < 0) d_hs_first = n;
        d_hs_cnt++;
      end
      if ({d_r, d_g, d_b} === 12'hF00) begin
        if (d_red_first < 0) d_red_first = n;
        d_red_cnt++;
      end
    end
    if (n >= 2 && n < 2118 && s_vs === 1'b0) begin
      if (s_vs_first < 0) s_vs_first = n;
      s_vs_cnt++;
    end
    if (n == 1278) d_addr_639 = d_addr;
    if (n == 3200) d_addr_l2 = d_addr;
    if (int'(s_addr) > s_addr_max) s_addr_max = int'(s_addr);
    if (s_fs === 1'b1) s_fs_q.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) n++;
    #1;
    check_all();
  endtask

  initial begin
    seed = $urandom;
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n = 0;
      check_all();
    end

    reset = 1'b1;
    mode = 1'b1;
    clear_stats();
    for (int i = 0; i < 4800; i++) step();
    chk("d_hs_first", 32'(d_hs_first), 32'd1314);
    chk("d_hs_len", 32'(d_hs_cnt), 32'd192);
    chk("d_red_first", 32'(d_red_first), 32'd22);
    chk("d_red_len", 32'(d_red_cnt), 32'd4);
    chk("d_addr_h639", 32'(d_addr_639), 32'd319);
    chk("d_addr_line2", 32'(d_addr_l2), 32'd320);
    chk("s_vs_first", 32'(s_vs_first), 32'd1658);
    chk("s_vs_len", 32'(s_vs_cnt), 32'd184);
    chk("s_addr_max", 32'(s_addr_max), 32'd127);
    chk("s_fs_count", 32'(s_fs_q.size()), 32'd2);
    if (s_fs_q.size() >= 2) begin
      chk("s_fs_first", 32'(s_fs_q[0]), 32'd1472);
      chk("s_fs_period", 32'(s_fs_q[1] - s_fs_q[0]), 32'd2116);
    end

    for (int k = 0; k < 3000; k++) begin
      if (((n / 2) % 1058) / 46 == 10) break;
      step();
    end
    reset = 1'b0;
    mode = 1'b0;
    seed = $urandom;
    @(posedge clk);
    #1;
    n = 0;
    check_all();
    reset = 1'b1;
    clear_stats();
    for (int i = 0; i < 4300; i++) step();
    chk("s_fs_count2", 32'(s_fs_q.size()), 32'd2);
    if (s_fs_q.size() >= 2) begin
      chk("s_fs_first2", 32'(s_fs_q[0]), 32'd1472);
      chk("s_fs_period2", 32'(s_fs_q[1] - s_fs_q[0]), 32'd2116);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
